// File: rtl/sh7604_intc_pkg.sv
// rtl/sh7604_intc_pkg.sv - shared types, register map and constants for the SH7604 interrupt controller
// Purpose: register layouts, init/write/read masks, register addresses and the arbiter source tuple.
// Ports: none (package).
package sh7604_intc_pkg;

    localparam int NUM_SRC = 14;
    localparam int NUM_REG = 8;

    typedef struct packed { logic [3:0] divu; logic [3:0] dmac; logic [3:0] wdt; logic [3:0] rsv; } ipra_t;
    typedef struct packed { logic [3:0] sci; logic [3:0] frt; logic [7:0] rsv; } iprb_t;
    typedef struct packed { logic rsv_h; logic [6:0] vec_h; logic rsv_l; logic [6:0] vec_l; } vcr_t;
    typedef struct packed { logic nmil; logic [5:0] rsv_h; logic nmie; logic [6:0] rsv_l; logic vecmd; } icr_t;

    // One arbiter candidate: request line, programmed level, vector.
    typedef struct packed { logic req; logic [3:0] lvl; logic [7:0] vec; } src_t;

    typedef enum logic [2:0] {
        REG_IPRA, REG_IPRB, REG_VCRA, REG_VCRB, REG_VCRC, REG_VCRD, REG_VCRWDT, REG_ICR
    } reg_idx_t;

    localparam logic [31:0] IPRA_ADDR   = 32'hFFFF_FEE2;
    localparam logic [31:0] IPRB_ADDR   = 32'hFFFF_FE60;
    localparam logic [31:0] VCRA_ADDR   = 32'hFFFF_FE62;
    localparam logic [31:0] VCRB_ADDR   = 32'hFFFF_FE64;
    localparam logic [31:0] VCRC_ADDR   = 32'hFFFF_FE66;
    localparam logic [31:0] VCRD_ADDR   = 32'hFFFF_FE68;
    localparam logic [31:0] VCRWDT_ADDR = 32'hFFFF_FEE4;
    localparam logic [31:0] ICR_ADDR    = 32'hFFFF_FEE0;

    localparam logic [15:0] IPRA_INIT  = 16'h0000;
    localparam logic [15:0] IPRB_INIT  = 16'h0000;
    localparam logic [15:0] VCR_INIT   = 16'h0000;
    localparam logic [15:0] ICR_INIT   = 16'h0000;

    localparam logic [15:0] IPRA_WMASK = 16'hFFF0;
    localparam logic [15:0] IPRB_WMASK = 16'hFF00;
    localparam logic [15:0] VCR_WMASK  = 16'h7F7F;
    localparam logic [15:0] VCRD_WMASK = 16'h7F00;
    localparam logic [15:0] ICR_WMASK  = 16'h0101;

    localparam logic [15:0] IPRA_RMASK = 16'hFFF0;
    localparam logic [15:0] IPRB_RMASK = 16'hFF00;
    localparam logic [15:0] VCR_RMASK  = 16'h7F7F;
    localparam logic [15:0] VCRD_RMASK = 16'h7F00;
    localparam logic [15:0] ICR_RMASK  = 16'h8101;

    function automatic logic [31:0] reg_addr(input reg_idx_t idx);
        case (idx)
            REG_IPRA:   return IPRA_ADDR;
            REG_IPRB:   return IPRB_ADDR;
            REG_VCRA:   return VCRA_ADDR;
            REG_VCRB:   return VCRB_ADDR;
            REG_VCRC:   return VCRC_ADDR;
            REG_VCRD:   return VCRD_ADDR;
            REG_VCRWDT: return VCRWDT_ADDR;
            default:    return ICR_ADDR;
        endcase
    endfunction

    function automatic logic [15:0] reg_wmask(input reg_idx_t idx);
        case (idx)
            REG_IPRA: return IPRA_WMASK;
            REG_IPRB: return IPRB_WMASK;
            REG_VCRD: return VCRD_WMASK;
            REG_ICR:  return ICR_WMASK;
            default:  return VCR_WMASK;
        endcase
    endfunction

    function automatic logic [15:0] reg_rmask(input reg_idx_t idx);
        case (idx)
            REG_IPRA: return IPRA_RMASK;
            REG_IPRB: return IPRB_RMASK;
            REG_VCRD: return VCRD_RMASK;
            REG_ICR:  return ICR_RMASK;
            default:  return VCR_RMASK;
        endcase
    endfunction

    function automatic logic [15:0] reg_init(input reg_idx_t idx);
        case (idx)
            REG_IPRA: return IPRA_INIT;
            REG_IPRB: return IPRB_INIT;
            REG_ICR:  return ICR_INIT;
            default:  return VCR_INIT;
        endcase
    endfunction

    function automatic src_t mk_src(input logic req, input logic [3:0] lvl, input logic [7:0] vec);
        return '{req: req, lvl: lvl, vec: vec};
    endfunction

endpackage

// File: rtl/sh7604_intc_if.sv
// rtl/sh7604_intc_if.sv - internal bus and CPU interrupt handshake bundle for the INTC
// Purpose: groups IBUS register access and the INT_* request/ack signals.
// Ports: master = CPU/bus side, slave = INTC side.
interface sh7604_intc_if;
    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DI;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;
    logic [3:0]  INT_LVL;
    logic        INT_NMI;
    logic [7:0]  INT_VEC;
    logic        INT_ACK;

    modport master (
        output IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ, INT_ACK,
        input  IBUS_DO, IBUS_BUSY, IBUS_ACT, INT_LVL, INT_NMI, INT_VEC
    );

    modport slave (
        input  IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ, INT_ACK,
        output IBUS_DO, IBUS_BUSY, IBUS_ACT, INT_LVL, INT_NMI, INT_VEC
    );
endinterface

// File: rtl/sh7604_intc_arb.sv
// rtl/sh7604_intc_arb.sv - combinational priority arbiter over the 14 INTC sources
// Purpose: picks the highest-level requesting source; ties go to the lower index.
// Ports: i_src[14] {req,lvl,vec} in; o_lvl (0 = none), o_vec out.
module sh7604_intc_arb
    import sh7604_intc_pkg::*;
(
    input  src_t       i_src [NUM_SRC],
    output logic [3:0] o_lvl,
    output logic [7:0] o_vec
);

    logic [3:0] w_lvl;
    logic [7:0] w_vec;

    // Strict greater-than keeps the earliest index on equal levels; a level of 0 never wins.
    always_comb begin
        w_lvl = 4'd0;
        w_vec = 8'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_src[i].req && (i_src[i].lvl > w_lvl)) begin
                w_lvl = i_src[i].lvl;
                w_vec = i_src[i].vec;
            end
        end
    end

    assign o_lvl = w_lvl;
    assign o_vec = w_vec;

endmodule

// File: rtl/sh7604_intc.sv
// rtl/sh7604_intc.sv - SH7604 on-chip interrupt controller top
// Purpose: IPR/VCR/ICR registers, NMI edge latch, source resolution and registered INT_* outputs.
// Ports: CLK, RST_N (async), CE_R/CE_F phase enables, EN, RES_N (sync soft reset), NMI_N, IRL_N,
//        EXT_VEC, peripheral request lines and vectors, NMI_LVL, bus_if (IBUS + INT handshake).
module sh7604_intc
    import sh7604_intc_pkg::*;
#(
    parameter logic [7:0] IRL_AUTOVEC_BASE = 8'd64
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE_R,
    input  logic       CE_F,
    input  logic       EN,
    input  logic       RES_N,
    input  logic       NMI_N,
    input  logic [3:0] IRL_N,
    input  logic [7:0] EXT_VEC,
    input  logic       FRT_ICI, FRT_OCIA, FRT_OCIB, FRT_OVI,
    input  logic       SCI_ERI, SCI_RXI, SCI_TXI, SCI_TEI,
    input  logic       WDT_ITI, BSC_CMI, DIVU_OVFI, DMAC0_TEI, DMAC1_TEI,
    input  logic [7:0] DMAC0_VEC,
    input  logic [7:0] DMAC1_VEC,
    input  logic [7:0] DIVU_VEC,
    output logic       NMI_LVL,
    sh7604_intc_if.slave bus_if
);

    logic [15:0] r_reg [NUM_REG];
    logic [15:0] w_wdata [NUM_REG];
    logic [NUM_REG-1:0] w_hit;
    logic        w_act;
    logic [31:0] w_reg_do;
    logic [31:0] r_reg_do;
    logic        r_nmi_q, r_nmi_vld, r_nmi;
    logic [3:0]  r_int_lvl;
    logic [7:0]  r_int_vec;

    ipra_t w_ipra;
    iprb_t w_iprb;
    vcr_t  w_vcra, w_vcrb, w_vcrc, w_vcrd, w_vcrwdt;
    icr_t  w_icr;

    assign w_ipra   = r_reg[REG_IPRA];
    assign w_iprb   = r_reg[REG_IPRB];
    assign w_vcra   = r_reg[REG_VCRA];
    assign w_vcrb   = r_reg[REG_VCRB];
    assign w_vcrc   = r_reg[REG_VCRC];
    assign w_vcrd   = r_reg[REG_VCRD];
    assign w_vcrwdt = r_reg[REG_VCRWDT];
    assign w_icr    = r_reg[REG_ICR];

    // Registers sit in halfwords of 32-bit words: offset 0 uses lanes [3:2], offset 2 lanes [1:0].
    always_comb begin
        logic [31:0] w_addr;
        logic [1:0]  w_be;
        logic [15:0] w_d, w_m, w_rd;
        w_act    = 1'b0;
        w_reg_do = '0;
        w_hit    = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            w_addr     = reg_addr(reg_idx_t'(i));
            w_be       = w_addr[1] ? bus_if.IBUS_BA[1:0] : bus_if.IBUS_BA[3:2];
            w_d        = w_addr[1] ? bus_if.IBUS_DI[15:0] : bus_if.IBUS_DI[31:16];
            w_m        = {{8{w_be[1]}}, {8{w_be[0]}}} & reg_wmask(reg_idx_t'(i));
            w_wdata[i] = (r_reg[i] & ~w_m) | (w_d & w_m);
            w_rd       = r_reg[i] & reg_rmask(reg_idx_t'(i));
            if (i == int'(REG_ICR)) w_rd[15] = r_nmi_q;
            w_hit[i]   = bus_if.IBUS_REQ && (bus_if.IBUS_A[31:2] == w_addr[31:2]);
            if (w_hit[i]) begin
                w_act = 1'b1;
                if (w_addr[1]) w_reg_do[15:0]  = w_rd;
                else           w_reg_do[31:16] = w_rd;
            end
        end
    end

    // Source table; index order is the tie-break order.
    src_t       w_src [NUM_SRC];
    logic [3:0] w_irl_lvl;
    logic [3:0] w_arb_lvl;
    logic [7:0] w_arb_vec;

    assign w_irl_lvl = ~IRL_N;

    always_comb begin
        w_src[0]  = mk_src(IRL_N != 4'hF, w_irl_lvl,
                           w_icr.vecmd ? EXT_VEC : IRL_AUTOVEC_BASE + {5'd0, w_irl_lvl[3:1]});
        w_src[1]  = mk_src(DIVU_OVFI, w_ipra.divu, DIVU_VEC);
        w_src[2]  = mk_src(DMAC0_TEI, w_ipra.dmac, DMAC0_VEC);
        w_src[3]  = mk_src(DMAC1_TEI, w_ipra.dmac, DMAC1_VEC);
        w_src[4]  = mk_src(WDT_ITI,   w_ipra.wdt,  {1'b0, w_vcrwdt.vec_h});
        w_src[5]  = mk_src(BSC_CMI,   w_ipra.wdt,  {1'b0, w_vcrwdt.vec_l});
        w_src[6]  = mk_src(SCI_ERI,   w_iprb.sci,  {1'b0, w_vcra.vec_h});
        w_src[7]  = mk_src(SCI_RXI,   w_iprb.sci,  {1'b0, w_vcra.vec_l});
        w_src[8]  = mk_src(SCI_TXI,   w_iprb.sci,  {1'b0, w_vcrb.vec_h});
        w_src[9]  = mk_src(SCI_TEI,   w_iprb.sci,  {1'b0, w_vcrb.vec_l});
        w_src[10] = mk_src(FRT_ICI,   w_iprb.frt,  {1'b0, w_vcrc.vec_h});
        w_src[11] = mk_src(FRT_OCIA,  w_iprb.frt,  {1'b0, w_vcrc.vec_l});
        w_src[12] = mk_src(FRT_OCIB,  w_iprb.frt,  {1'b0, w_vcrc.vec_l});
        w_src[13] = mk_src(FRT_OVI,   w_iprb.frt,  {1'b0, w_vcrd.vec_h});
    end

    sh7604_intc_arb u_arb (
        .i_src (w_src),
        .o_lvl (w_arb_lvl),
        .o_vec (w_arb_vec)
    );

    // r_nmi_vld suppresses a false edge on the first sample after reset.
    logic w_nmi_edge, w_nmi_next;
    assign w_nmi_edge = r_nmi_vld && (w_icr.nmie ? (!r_nmi_q && NMI_N) : (r_nmi_q && !NMI_N));
    // The next latch value feeds the outputs so NMI also appears one CE_R after its edge.
    assign w_nmi_next = w_nmi_edge || (r_nmi && !(bus_if.INT_ACK && r_nmi));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_REG; i++) r_reg[i] <= reg_init(reg_idx_t'(i));
            r_nmi_q   <= 1'b0;
            r_nmi_vld <= 1'b0;
            r_nmi     <= 1'b0;
            r_int_lvl <= 4'd0;
            r_int_vec <= 8'd0;
        end else if (!RES_N) begin
            for (int i = 0; i < NUM_REG; i++) r_reg[i] <= reg_init(reg_idx_t'(i));
            r_nmi_q   <= 1'b0;
            r_nmi_vld <= 1'b0;
            r_nmi     <= 1'b0;
            r_int_lvl <= 4'd0;
            r_int_vec <= 8'd0;
        end else if (CE_R && EN) begin
            for (int i = 0; i < NUM_REG; i++) begin
                if (w_hit[i] && bus_if.IBUS_WE) r_reg[i] <= w_wdata[i];
            end
            r_nmi_q   <= NMI_N;
            r_nmi_vld <= 1'b1;
            r_nmi     <= w_nmi_next;
            r_int_lvl <= w_nmi_next ? 4'd15 : w_arb_lvl;
            r_int_vec <= w_nmi_next ? 8'd11 : w_arb_vec;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)       r_reg_do <= '0;
        else if (!RES_N)  r_reg_do <= '0;
        else if (CE_F)    r_reg_do <= w_reg_do;
    end

    assign bus_if.IBUS_ACT  = w_act;
    assign bus_if.IBUS_DO   = w_act ? r_reg_do : 32'd0;
    assign bus_if.IBUS_BUSY = 1'b0;
    assign bus_if.INT_LVL   = r_int_lvl;
    assign bus_if.INT_NMI   = r_nmi;
    assign bus_if.INT_VEC   = r_int_vec;
    assign NMI_LVL          = r_nmi_q;

endmodule
